// File: rtl/store_monitor.sv
// store_monitor
// ----------------------------------------------------------------------------
// Self-check block for the multicycle MIPS top level. It watches the
// processor's data-memory write port, classifies each store, and holds a
// sticky verdict. The program can then be checked on hardware without a
// simulation bench. It also runs a cycle watchdog and captures the first
// illegal store.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        asynchronous active-low reset (0 = in reset)
//   MemWrite     store strobe, one cycle high per store
//   dataadr      store byte address
//   WriteData    store data
//   done         a verdict has been reached (any terminal state)
//   pass         the completion store was seen with the expected data
//   fail         an illegal store was seen
//   timeout      the watchdog expired before any verdict
//   store_count  stores accepted while running (saturating)
//   cycle_count  clocks spent running (saturating)
//   fail_addr    address of the failing store
//   fail_data    data of the failing store
// ----------------------------------------------------------------------------
module store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd84,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] IGNORE_ADDR    = 32'd80,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      WriteData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] store_count,
  output logic [31:0]      cycle_count,
  output logic [31:0]      fail_addr,
  output logic [31:0]      fail_data
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic             running;
  logic             store_event;
  logic             capture;
  logic [CNT_W-1:0] store_count_next;
  logic [31:0]      cycle_count_next;

  assign running     = (state_reg == ST_RUN);
  assign store_event = running && MemWrite;

  // Next-state decision. The store checks come first, so a store on the
  // same edge as watchdog expiry always wins over the timeout.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    if (running) begin
      if (MemWrite) begin
        if (dataadr == PASS_ADDR && WriteData == PASS_DATA) begin
          state_next = ST_PASS;
        end else if (dataadr == IGNORE_ADDR) begin
          state_next = ST_RUN;
        end else begin
          state_next = ST_FAIL;
          capture    = 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 32'd0 &&
                   (cycle_count + 32'd1) == TIMEOUT_CYCLES) begin
        state_next = ST_TIMEOUT;
      end
    end
  end

  // Both counters saturate and are frozen outside RUN. The edge that
  // terminates the run is still counted because it is sampled in RUN.
  always_comb begin
    store_count_next = store_count;
    cycle_count_next = cycle_count;
    if (store_event && store_count != {CNT_W{1'b1}}) begin
      store_count_next = store_count + 1'b1;
    end
    if (running && cycle_count != 32'hFFFF_FFFF) begin
      cycle_count_next = cycle_count + 32'd1;
    end
  end

  // Verdict flags are registered from the next state. They are therefore
  // visible right after the deciding edge and are one-hot once done is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      store_count <= '0;
      cycle_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
    end else begin
      state_reg   <= state_next;
      done        <= (state_next != ST_RUN);
      pass        <= (state_next == ST_PASS);
      fail        <= (state_next == ST_FAIL);
      timeout     <= (state_next == ST_TIMEOUT);
      store_count <= store_count_next;
      cycle_count <= cycle_count_next;
      if (capture) begin
        fail_addr <= dataadr;
        fail_data <= WriteData;
      end
    end
  end

endmodule
